// File: rtl/madgwick_pkg.sv
// madgwick_pkg: shared widths, sample/quaternion records and scheduler states
package madgwick_pkg;
  localparam int ACC_WIDTH = 16;
  localparam int GYRO_WIDTH = 16;
  localparam int Q_WIDTH = 32;
  typedef struct packed {
    logic [ACC_WIDTH-1:0] a_x, a_y, a_z;
    logic [GYRO_WIDTH-1:0] w_x, w_y, w_z;
  } imu_sample_t;
  typedef struct packed {
    logic [Q_WIDTH-1:0] q_w, q_x, q_y, q_z;
  } quat_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECOVER} sched_state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/madgwick_sample_scheduler_if.sv
// madgwick_sample_scheduler_if: scheduler-to-filter-core handshake bus
interface madgwick_sample_scheduler_if;
  import madgwick_pkg::*;
  logic core_rst_n, core_valid_in, core_ready_in, core_valid_out, core_ready_out;
  imu_sample_t core_data;
  quat_t core_q;
  modport master(
    output core_rst_n, core_valid_in, core_data, core_ready_out,
    input core_ready_in, core_valid_out, core_q
  );
  modport slave(
    input core_rst_n, core_valid_in, core_data, core_ready_out,
    output core_ready_in, core_valid_out, core_q
  );
endinterface

// File: rtl/madgwick_sample_fifo.sv
// madgwick_sample_fifo: drop-oldest sample FIFO, flags each discarded entry
module madgwick_sample_fifo
  import madgwick_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  imu_sample_t din,
  output imu_sample_t dout,
  output logic        empty,
  output logic        overrun
);
  localparam int AW = $clog2(DEPTH);
  imu_sample_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic drop;
  assign empty = count == '0;
  assign drop = push && !pop && count == (AW+1)'(DEPTH);
  assign overrun = drop;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= (pop || drop) ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(push && !drop) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/madgwick_sample_scheduler.sv
// madgwick_sample_scheduler: paces buffered IMU samples into the filter core, one update per tick
module madgwick_sample_scheduler
  import madgwick_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PERIOD_WIDTH = 24,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    smp_valid,
  output logic                    smp_ready,
  input  imu_sample_t             smp_data,
  madgwick_sample_scheduler_if.master core,
  output quat_t                   q_out,
  output logic                    q_valid,
  output logic                    busy,
  output logic [15:0]             overrun_cnt,
  output logic [15:0]             timeout_cnt
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  sched_state_t state, next;
  imu_sample_t head, data_q;
  logic empty, overrun, issue, hs_in, hs_out, expire, cap, wrap, tick_pending, rst_n_q, rc;
  logic [PERIOD_WIDTH-1:0] timer, per_q, lim;
  logic [WW-1:0] wd;
  madgwick_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .flush(!enable), .push(smp_valid && enable), .pop(issue),
    .din(smp_data), .dout(head), .empty(empty), .overrun(overrun)
  );
  assign smp_ready = enable;
  // period is sampled at the start of each count so a change lands on the next wrap
  assign lim = (timer == '0) ? period : per_q;
  assign wrap = enable && lim != '0 && timer == lim - 1'b1;
  assign issue = state == IDLE && enable && !empty && (period == '0 || tick_pending);
  assign hs_in = core.core_valid_in && core.core_ready_in;
  assign hs_out = core.core_valid_out && core.core_ready_out;
  assign expire = wd == WW'(TIMEOUT_CYCLES - 1);
  assign cap = enable && state == WAIT && hs_out && !expire;
  assign core.core_valid_in = state == ISSUE;
  assign core.core_ready_out = state == WAIT;
  assign core.core_data = data_q;
  assign core.core_rst_n = rst_n_q;
  assign busy = state != IDLE;
  always_comb begin
    next = !enable ? IDLE
      : ((state == ISSUE || state == WAIT) && expire) ? RECOVER
      : state == IDLE ? (issue ? ISSUE : IDLE)
      : state == ISSUE ? (hs_in ? WAIT : ISSUE)
      : state == WAIT ? (hs_out ? IDLE : WAIT)
      : (rc ? IDLE : RECOVER);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data_q <= '0;
      q_out <= '0;
      q_valid <= 1'b0;
      rst_n_q <= 1'b0;
      overrun_cnt <= '0;
      timeout_cnt <= '0;
      timer <= '0;
      per_q <= '0;
      tick_pending <= 1'b0;
      wd <= '0;
      rc <= 1'b0;
    end else begin
      state <= next;
      rst_n_q <= enable && state != RECOVER;
      timer <= (!enable || wrap || lim == '0) ? '0 : timer + 1'b1;
      per_q <= (timer == '0) ? period : per_q;
      tick_pending <= enable && (wrap || (tick_pending && !issue));
      wd <= ((state == ISSUE || state == WAIT) && (next == ISSUE || next == WAIT)) ? wd + 1'b1 : '0;
      rc <= state == RECOVER && !rc;
      data_q <= issue ? head : data_q;
      q_valid <= cap;
      q_out <= cap ? core.core_q : q_out;
      overrun_cnt <= overrun ? sat_inc(overrun_cnt) : overrun_cnt;
      timeout_cnt <= (next == RECOVER && state != RECOVER) ? sat_inc(timeout_cnt) : timeout_cnt;
    end
  end
endmodule

// File: tb/tb_madgwick_sample_scheduler.sv
// tb_madgwick_sample_scheduler: directed checks against a small behavioural filter core
module tb_madgwick_sample_scheduler;
  import madgwick_pkg::*;
  logic clk = 0, rst = 1, enable = 0, smp_valid = 0, smp_ready, q_valid, busy;
  logic [23:0] period = '0;
  imu_sample_t smp_data = '0;
  quat_t q_out;
  logic [15:0] overrun_cnt, timeout_cnt;
  madgwick_sample_scheduler_if bus();
  madgwick_sample_scheduler #(.FIFO_DEPTH(4), .PERIOD_WIDTH(24), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
    .core(bus), .q_out(q_out), .q_valid(q_valid), .busy(busy),
    .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt)
  );
  always #5 clk = ~clk;
  // core model: accepts when rdy, answers lat cycles later with {sample, tag}
  logic rdy = 0, never = 0, pend = 0;
  int lat = 10, cnt = 0;
  imu_sample_t cd = '0;
  assign bus.core_ready_in = rdy;
  assign bus.core_valid_out = pend && cnt == 0 && !never;
  assign bus.core_q = {cd, 32'h5A5A_0001};
  always @(posedge clk) begin
    if (bus.core_rst_n !== 1'b1) pend <= 1'b0;
    else if (bus.core_valid_in && bus.core_ready_in) begin
      pend <= 1'b1;
      cnt <= lat - 1;
      cd <= bus.core_data;
    end else if (bus.core_valid_out && bus.core_ready_out) pend <= 1'b0;
    else if (pend && cnt != 0) cnt <= cnt - 1;
  end
  int n_cmp = 0, n_err = 0, qv_cnt = 0;
  always @(negedge clk) if (q_valid) qv_cnt++;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic imu_sample_t smp(input logic [7:0] i);
    return {8'hA0, i, 8'hA1, i, 8'hA2, i, 8'hB0, i, 8'hB1, i, 8'hB2, i};
  endfunction
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [7:0] i);
    smp_data = smp(i);
    smp_valid = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
  endtask
  initial begin
    int pulses, busy_at, k, t, low, qv0, seen;
    int hs [3];
    imu_sample_t hd [3];
    quat_t got, qsave;
    step(3);
    check("rst_core_rst_n", bus.core_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_q_out", q_out, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_timeout", timeout_cnt, 0);
    check("rst_valid_in", bus.core_valid_in, 0);
    check("rst_ready_out", bus.core_ready_out, 0);
    check("rst_core_data", bus.core_data, 0);
    rst = 0; enable = 1; rdy = 1;
    step(2);
    check("en_core_rst_n", bus.core_rst_n, 1);
    check("en_smp_ready", smp_ready, 1);
    // single sample, free-run
    push(1);
    check("lat_n1_valid_in", bus.core_valid_in, 0);
    step(1);
    check("lat_n2_valid_in", bus.core_valid_in, 1);
    check("lat_n2_data", bus.core_data, smp(1));
    check("lat_n2_busy", busy, 1);
    pulses = 0; busy_at = 1; got = '0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (q_valid) begin pulses++; got = q_out; busy_at = busy; end
    end
    check("single_pulses", pulses, 1);
    check("single_q_out", got, {smp(1), 32'h5A5A_0001});
    check("single_busy_at_q", busy_at, 0);
    // paced issue: one per 100-cycle tick
    period = 24'd100;
    push(11); push(12); push(13);
    k = 0;
    for (int i = 0; i < 450; i++) begin
      if (bus.core_valid_in && bus.core_ready_in && k < 3) begin hs[k] = i; hd[k] = bus.core_data; k++; end
      step(1);
    end
    check("paced_count", k, 3);
    if (k == 3) begin
      check("paced_gap1", hs[1] - hs[0], 100);
      check("paced_gap2", hs[2] - hs[1], 100);
      check("paced_data0", hd[0], smp(11));
      check("paced_data2", hd[2], smp(13));
    end
    check("paced_overrun", overrun_cnt, 0);
    period = '0;
    step(2);
    // stalled core: S20 held in ISSUE, 21..26 overflow the 4-deep FIFO
    rdy = 0;
    push(20);
    for (int i = 21; i <= 26; i++) push(8'(i));
    check("stall_overrun", overrun_cnt, 2);
    check("stall_held_data", bus.core_data, smp(20));
    check("stall_held_valid", bus.core_valid_in, 1);
    rdy = 1;
    for (int i = 0; i < 40 && !q_valid; i++) step(1);
    check("stall_release_q", q_valid, 1);
    for (int i = 0; i < 10 && !bus.core_valid_in; i++) step(1);
    check("stall_next_valid", bus.core_valid_in, 1);
    check("stall_next_data", bus.core_data, smp(23));
    step(100);
    check("stall_overrun_kept", overrun_cnt, 2);
    // watchdog: core never answers
    never = 1;
    qsave = q_out; qv0 = qv_cnt;
    push(30);
    for (int i = 0; i < 10 && !bus.core_valid_in; i++) step(1);
    check("wd_issue_seen", bus.core_valid_in, 1);
    t = 0;
    while (t < 100 && !(busy && !bus.core_valid_in && !bus.core_ready_out)) begin step(1); t++; end
    check("wd_recover_delay", t, 64);
    check("wd_rst_n_pre", bus.core_rst_n, 1);
    low = 0;
    for (int i = 0; i < 6; i++) begin step(1); if (!bus.core_rst_n) low++; end
    check("wd_rst_n_low", low, 2);
    check("wd_timeout_cnt", timeout_cnt, 1);
    check("wd_q_out_kept", q_out, qsave);
    check("wd_no_q_valid", qv_cnt - qv0, 0);
    check("wd_idle", busy, 0);
    never = 0;
    step(2);
    // enable dropped during WAIT
    qsave = q_out; qv0 = qv_cnt;
    push(40);
    for (int i = 0; i < 10 && !bus.core_ready_out; i++) step(1);
    check("dis_in_wait", bus.core_ready_out, 1);
    push(41);
    enable = 0;
    step(1);
    check("dis_busy", busy, 0);
    check("dis_ready_out", bus.core_ready_out, 0);
    check("dis_valid_in", bus.core_valid_in, 0);
    check("dis_core_rst_n", bus.core_rst_n, 0);
    step(20);
    check("dis_no_q_valid", qv_cnt - qv0, 0);
    check("dis_q_out_kept", q_out, qsave);
    check("dis_overrun_kept", overrun_cnt, 2);
    check("dis_timeout_kept", timeout_cnt, 1);
    enable = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin step(1); if (busy) seen++; end
    check("dis_fifo_flushed", seen, 0);
    // reset in the middle of ISSUE
    rdy = 0;
    push(50);
    step(1);
    check("mid_issue_valid", bus.core_valid_in, 1);
    rst = 1;
    step(1);
    check("mid_rst_valid_in", bus.core_valid_in, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_core_rst_n", bus.core_rst_n, 0);
    check("mid_rst_overrun", overrun_cnt, 0);
    check("mid_rst_timeout", timeout_cnt, 0);
    check("mid_rst_q_out", q_out, 0);
    check("mid_rst_core_data", bus.core_data, 0);
    check("mid_rst_ready_out", bus.core_ready_out, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
